// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port, byte-addressed, big-endian 16-bit data memory
// between two requesters:
//   port A - pipeline MEM stage
//   port B - program/data loader and debug port
//
// Every transaction runs the same three-cycle sequence IDLE -> ACCESS -> RESP.
// Contended IDLE cycles are resolved round-robin. The arbiter is the only
// driver of the memory address, write-data and write-enable inputs.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_gnt)
//   a_gnt                    port A accepted (1-cycle pulse, ACCESS cycle)
//   a_ack/a_rdata/a_err      port A completion (1-cycle pulse, RESP cycle)
//   b_*                      same set for port B
//   m_addr/m_wdata/m_we      memory control, driven only by this block
//   m_rdata                  memory read data {mem[m_addr], mem[m_addr+1]}
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH = 100,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          b_err,

    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Highest address whose two-byte word still fits inside the memory.
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 2);

    localparam int NPORT = 2;

    // Per-port views of the request inputs, index 0 = A, index 1 = B.
    logic          req_w   [NPORT];
    logic          we_w    [NPORT];
    logic [AW-1:0] addr_w  [NPORT];
    logic [DW-1:0] wdata_w [NPORT];

    assign req_w[0]   = a_req;
    assign we_w[0]    = a_we;
    assign addr_w[0]  = a_addr;
    assign wdata_w[0] = a_wdata;
    assign req_w[1]   = b_req;
    assign we_w[1]    = b_we;
    assign addr_w[1]  = b_addr;
    assign wdata_w[1] = b_wdata;

    // Sequencer state and latched transaction
    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;        // port favoured on contention
    logic          id_q, id_d;          // port that owns the current transaction
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          m_we_q, m_we_d;

    // Registered per-port handshake outputs
    logic          gnt_q   [NPORT];
    logic          gnt_d   [NPORT];
    logic          ack_q   [NPORT];
    logic          ack_d   [NPORT];
    logic          perr_q  [NPORT];
    logic          perr_d  [NPORT];
    logic [DW-1:0] rdata_q [NPORT];
    logic [DW-1:0] rdata_d [NPORT];

    logic          win;
    logic          win_err;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        we_d      = we_q;
        err_d     = err_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = 1'b0;
        win       = 1'b0;
        win_err   = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            gnt_d[i]   = 1'b0;
            ack_d[i]   = 1'b0;
            perr_d[i]  = 1'b0;
            rdata_d[i] = rdata_q[i];
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req_w[0] || req_w[1]) begin
                    // Contention goes to ptr; otherwise the lone requester wins.
                    win       = (req_w[0] && req_w[1]) ? ptr_q : req_w[1];
                    win_err   = (addr_w[win] > LAST_WORD);
                    id_d      = win;
                    we_d      = we_w[win];
                    err_d     = win_err;
                    // Address/data move here and then stay put until the
                    // next transaction, so the memory never sees stray values.
                    m_addr_d  = addr_w[win];
                    m_wdata_d = wdata_w[win];
                    // Write strobe is only ever high for the ACCESS cycle.
                    m_we_d    = we_w[win] & ~win_err;
                    gnt_d[win] = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Writes and rejected accesses return zero, never stale data.
                rdata_d[id_q] = (err_q || we_q) ? '0 : m_rdata;
                ack_d[id_q]   = 1'b1;
                perr_d[id_q]  = err_q;
                state_d       = ST_RESP;
            end

            ST_RESP: begin
                ptr_d   = ~id_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            we_q      <= we_d;
            err_q     <= err_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            always_ff @(posedge clk) begin
                if (rst) begin
                    gnt_q[gi]   <= 1'b0;
                    ack_q[gi]   <= 1'b0;
                    perr_q[gi]  <= 1'b0;
                    rdata_q[gi] <= '0;
                end else begin
                    gnt_q[gi]   <= gnt_d[gi];
                    ack_q[gi]   <= ack_d[gi];
                    perr_q[gi]  <= perr_d[gi];
                    rdata_q[gi] <= rdata_d[gi];
                end
            end
        end
    endgenerate

    assign a_gnt   = gnt_q[0];
    assign a_ack   = ack_q[0];
    assign a_err   = perr_q[0];
    assign a_rdata = rdata_q[0];
    assign b_gnt   = gnt_q[1];
    assign b_ack   = ack_q[1];
    assign b_err   = perr_q[1];
    assign b_rdata = rdata_q[1];

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    // Reset gates the strobe immediately, so a reset landing in the middle
    // of an ACCESS cycle cannot let the write through.
    assign m_we    = m_we_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a 100-byte big-endian memory model.
// Inputs are driven on the falling edge and outputs are sampled there too,
// half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_ack, a_err, b_gnt, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_we;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(100), .AW(16), .DW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_gnt   (a_gnt),
        .a_ack   (a_ack),
        .a_rdata (a_rdata),
        .a_err   (a_err),
        .b_req   (b_req),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_gnt   (b_gnt),
        .b_ack   (b_ack),
        .b_rdata (b_rdata),
        .b_err   (b_err),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_we    (m_we),
        .m_rdata (m_rdata)
    );

    // Memory model: 100 bytes, word = {mem[addr], mem[addr+1]}.
    logic [7:0]  mem [0:99];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [7:0]  poke_byte = 8'h0;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_byte;
        end else if (m_we && m_addr < 16'd99) begin
            mem[m_addr]         <= m_wdata[15:8];
            mem[m_addr + 16'd1] <= m_wdata[7:0];
        end
        if (m_we) we_cnt <= we_cnt + 1;
    end

    always_comb begin
        m_rdata = 16'h0;
        if (m_addr < 16'd99) m_rdata = {mem[m_addr], mem[m_addr + 16'd1]};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [15:0] addr, input logic [7:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_byte = data;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) poke(16'(i), 8'h00);
        tick();
        n_checks++;
        if ({a_gnt, a_ack, a_err, b_gnt, b_ack, b_err, m_we} !== 7'b0) begin
            $display("FAIL reset_flags: got %b required %b",
                     {a_gnt, a_ack, a_err, b_gnt, b_ack, b_err, m_we}, 7'b0);
            n_fail++;
        end
        n_checks++;
        if ({a_rdata, b_rdata} !== 32'h0) begin
            $display("FAIL reset_rdata: got %h required %h", {a_rdata, b_rdata}, 32'h0);
            n_fail++;
        end
        n_checks++;
        if ({m_addr, m_wdata} !== 32'h0) begin
            $display("FAIL reset_mem_bus: got %h required %h", {m_addr, m_wdata}, 32'h0);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        $display("txn: reset done");
    endtask

    task automatic test_read();
        int we_start;
        poke(16'd0, 8'h3C);
        poke(16'd1, 8'hAD);
        we_start = we_cnt;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0000;
        tick();                                   // cycle 1
        n_checks++;
        if ({a_gnt, a_ack, b_gnt, b_ack} !== 4'b1000) begin
            $display("FAIL read_gnt_cycle1: got %b required %b", {a_gnt, a_ack, b_gnt, b_ack}, 4'b1000);
            n_fail++;
        end
        a_req = 1'b0;
        tick();                                   // cycle 2
        n_checks++;
        if ({a_gnt, a_ack, a_err, b_gnt, b_ack} !== 5'b01000) begin
            $display("FAIL read_ack_cycle2: got %b required %b", {a_gnt, a_ack, a_err, b_gnt, b_ack}, 5'b01000);
            n_fail++;
        end
        n_checks++;
        if (a_rdata !== 16'h3CAD) begin
            $display("FAIL read_rdata: got %h required %h", a_rdata, 16'h3CAD);
            n_fail++;
        end
        tick();                                   // cycle 3
        n_checks++;
        if ({a_ack, a_rdata} !== {1'b0, 16'h3CAD}) begin
            $display("FAIL read_hold: got ack=%b rdata=%h required ack=0 rdata=3cad", a_ack, a_rdata);
            n_fail++;
        end
        n_checks++;
        if (we_cnt !== we_start) begin
            $display("FAIL read_no_write: got %0d write cycles required 0", we_cnt - we_start);
            n_fail++;
        end
        $display("txn: A read 0x0000 -> 0x%h", a_rdata);
    endtask

    task automatic test_write_then_read();
        int we_start;
        we_start = we_cnt;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0002; b_wdata = 16'h1463;
        tick();                                   // ACCESS
        n_checks++;
        if ({b_gnt, a_gnt, m_we, m_addr, m_wdata} !== {3'b101, 16'h0002, 16'h1463}) begin
            $display("FAIL write_access: got gnt_b=%b gnt_a=%b we=%b addr=%h wdata=%h required 1 0 1 0002 1463",
                     b_gnt, a_gnt, m_we, m_addr, m_wdata);
            n_fail++;
        end
        b_req = 1'b0;
        tick();                                   // RESP
        n_checks++;
        if ({b_ack, b_err, m_we, b_rdata} !== {3'b100, 16'h0000}) begin
            $display("FAIL write_resp: got ack=%b err=%b we=%b rdata=%h required 1 0 0 0000",
                     b_ack, b_err, m_we, b_rdata);
            n_fail++;
        end
        tick();
        n_checks++;
        if (we_cnt - we_start !== 1) begin
            $display("FAIL write_we_pulse: got %0d write cycles required 1", we_cnt - we_start);
            n_fail++;
        end
        n_checks++;
        if ({mem[2], mem[3]} !== 16'h1463) begin
            $display("FAIL write_mem: got %h required %h", {mem[2], mem[3]}, 16'h1463);
            n_fail++;
        end
        $display("txn: B write 0x0002 <- 0x1463");
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0002;
        tick();
        a_req = 1'b0;
        tick();
        n_checks++;
        if ({a_ack, a_rdata} !== {1'b1, 16'h1463}) begin
            $display("FAIL readback: got ack=%b rdata=%h required ack=1 rdata=1463", a_ack, a_rdata);
            n_fail++;
        end
        tick();
        $display("txn: A read 0x0002 -> 0x%h", a_rdata);
    endtask

    task automatic test_contention();
        logic exp_ag, exp_bg, exp_aa, exp_ba;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0000;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0004;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            // Grants at cycles 1,4,7,10 alternate A,B,A,B; acks one cycle later.
            exp_ag = (k % 3 == 1) && ((k / 3) % 2 == 0);
            exp_bg = (k % 3 == 1) && ((k / 3) % 2 == 1);
            exp_aa = (k % 3 == 2) && ((k / 3) % 2 == 0);
            exp_ba = (k % 3 == 2) && ((k / 3) % 2 == 1);
            n_checks++;
            if ({a_gnt, b_gnt, a_ack, b_ack} !== {exp_ag, exp_bg, exp_aa, exp_ba}) begin
                $display("FAIL contention_c%0d: got %b required %b", k,
                         {a_gnt, b_gnt, a_ack, b_ack}, {exp_ag, exp_bg, exp_aa, exp_ba});
                n_fail++;
            end
            if (a_gnt) $display("txn: contention cycle %0d grant A", k);
            if (b_gnt) $display("txn: contention cycle %0d grant B", k);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_out_of_range();
        int we_start;
        poke(16'd98, 8'h12);
        poke(16'd99, 8'h55);
        // Last legal word address
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'd98;
        tick();
        a_req = 1'b0;
        tick();
        n_checks++;
        if ({a_ack, a_err, a_rdata} !== {2'b10, 16'h1255}) begin
            $display("FAIL edge_read98: got ack=%b err=%b rdata=%h required 1 0 1255", a_ack, a_err, a_rdata);
            n_fail++;
        end
        tick();
        $display("txn: A read 98 -> 0x%h err=%b", a_rdata, a_err);
        we_start = we_cnt;
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'd99; a_wdata = 16'hFFFF;
        tick();
        n_checks++;
        if ({a_gnt, m_we} !== 2'b10) begin
            $display("FAIL oor_access: got gnt=%b we=%b required 1 0", a_gnt, m_we);
            n_fail++;
        end
        a_req = 1'b0;
        tick();
        n_checks++;
        if ({a_ack, a_err, a_rdata, b_ack, b_err} !== {2'b11, 16'h0000, 2'b00}) begin
            $display("FAIL oor_resp: got ack=%b err=%b rdata=%h b_ack=%b b_err=%b required 1 1 0000 0 0",
                     a_ack, a_err, a_rdata, b_ack, b_err);
            n_fail++;
        end
        tick();
        n_checks++;
        if (a_err !== 1'b0) begin
            $display("FAIL oor_err_pulse: got %b required %b", a_err, 1'b0);
            n_fail++;
        end
        n_checks++;
        if ({we_cnt - we_start, mem[99]} !== {32'd0, 8'h55}) begin
            $display("FAIL oor_no_write: got writes=%0d mem99=%h required 0 55", we_cnt - we_start, mem[99]);
            n_fail++;
        end
        $display("txn: A write 99 -> err=1 rdata=0x%h", a_rdata);
    endtask

    task automatic test_reset_mid_access();
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'd10; b_wdata = 16'hBEEF;
        tick();                                   // ACCESS
        n_checks++;
        if ({b_gnt, m_we} !== 2'b11) begin
            $display("FAIL midrst_access: got gnt=%b we=%b required 1 1", b_gnt, m_we);
            n_fail++;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (m_we !== 1'b0) begin
            $display("FAIL midrst_we_gate: got %b required %b", m_we, 1'b0);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if ({a_gnt, a_ack, a_err, b_gnt, b_ack, b_err, m_we, a_rdata, b_rdata, m_addr, m_wdata} !== 71'h0) begin
            $display("FAIL midrst_outputs: got b_gnt=%b b_ack=%b m_we=%b m_addr=%h m_wdata=%h required all 0",
                     b_gnt, b_ack, m_we, m_addr, m_wdata);
            n_fail++;
        end
        rst = 1'b0;
        b_req = 1'b0;
        tick();
        n_checks++;
        if ({b_ack, b_gnt} !== 2'b00) begin
            $display("FAIL midrst_no_ack: got ack=%b gnt=%b required 0 0", b_ack, b_gnt);
            n_fail++;
        end
        n_checks++;
        if ({mem[10], mem[11]} !== 16'h0000) begin
            $display("FAIL midrst_mem: got %h required %h", {mem[10], mem[11]}, 16'h0000);
            n_fail++;
        end
        $display("txn: B write 10 aborted by reset");
    endtask

    task automatic test_back_to_back();
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0000;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) a_req = 1'b0;
            tick();
            n_checks++;
            if ({a_gnt, a_ack, b_gnt, b_ack, b_err} !== {(k % 3 == 1) && (k < 10), (k % 3 == 2), 3'b000}) begin
                $display("FAIL b2b_c%0d: got %b required %b", k, {a_gnt, a_ack, b_gnt, b_ack, b_err},
                         {(k % 3 == 1) && (k < 10), (k % 3 == 2), 3'b000});
                n_fail++;
            end
            if (k % 3 == 2) begin
                n_checks++;
                if (a_rdata !== 16'h3CAD) begin
                    $display("FAIL b2b_rdata_c%0d: got %h required %h", k, a_rdata, 16'h3CAD);
                    n_fail++;
                end
                $display("txn: back-to-back A read cycle %0d -> 0x%h", k, a_rdata);
            end
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read();
        test_write_then_read();
        test_contention();
        test_out_of_range();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
